rd_pkt_out: RTL and testbench

Egress packet stage directly downstream of the SRAM block reader. It consumes the reader's per-packet stream: SOP pulse, header beat, data beats, then an EOP pulse carrying the trailing CRC word. It checks a running CRC-32 against that trailing word and buffers the packet in a tagged FIFO. It then replays the packet to the output port over a valid/ready handshake, so reader timing is decoupled from port backpressure.

---
 rtl/rd_pkt_out.sv | 227 ++++++++++++++++++++++
 tb/tb_rd_pkt_out.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_pkt_out.sv
// Egress packet stage: CRC-32 check of the reader stream, tagged FIFO and a valid/ready replay port.
// Optional statistics counters are built only when RD_PKT_OUT_STATS_EN is defined.
module rd_pkt_out #(
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 64,
    parameter int AFULL_TH = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_sop,
    input  logic              i_rd_vld,
    input  logic [DWIDTH-1:0] i_rd_data,
    input  logic              i_pkt_hdr_vld,
    input  logic              i_rd_eop,
    input  logic [DWIDTH-1:0] i_crc,
    output logic              o_buf_afull,
    output logic              o_tx_vld,
    input  logic              i_tx_rdy,
    output logic [DWIDTH-1:0] o_tx_data,
    output logic              o_tx_sop,
    output logic              o_tx_eop,
    output logic              o_tx_err,
    output logic              o_ovf_err,
    output logic              o_proto_err,
    output logic [15:0]       o_pkt_cnt,
    output logic [15:0]       o_crc_err_cnt,
    output logic [1:0]        o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DWIDTH + 3;
    localparam logic [AW:0]       DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]       AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [DWIDTH-1:0] CRC_POLY = DWIDTH'(32'h04C11DB7);
    localparam logic [DWIDTH-1:0] CRC_INIT = '1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_HDR = 2'd1,
        S_BODY     = 2'd2
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] crc_reg;
    logic [DWIDTH-1:0] hold_data;
    logic              hold_sop;
    logic              proto_err;
    logic              ovf_err;

    logic              push;
    logic [EW-1:0]     push_word;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       free_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              bypass;
    logic              drop;

    logic [EW-1:0]     out_word;
    logic              out_vld;
    logic              out_free;
    logic              tx_acc;

    // MSB-first, non-reflected CRC-32 over one full data word.
    function automatic logic [DWIDTH-1:0] crc_step(input logic [DWIDTH-1:0] c,
                                                   input logic [DWIDTH-1:0] d);
        logic [DWIDTH-1:0] r;
        r = c;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (r[DWIDTH-1] ^ d[i]) r = {r[DWIDTH-2:0], 1'b0} ^ CRC_POLY;
            else                    r = {r[DWIDTH-2:0], 1'b0};
        end
        return r;
    endfunction

    // The held word is released by the next event in BODY; the tag depends on which event it is.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (state == S_BODY) begin
            if (i_rd_sop) begin
                push      = 1'b1;
                push_word = {1'b1, 1'b1, hold_sop, hold_data};
            end else if (i_rd_eop) begin
                push      = 1'b1;
                push_word = {(crc_reg != i_crc), 1'b1, hold_sop, hold_data};
            end else if (i_rd_vld) begin
                push      = 1'b1;
                push_word = {1'b0, 1'b0, hold_sop, hold_data};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            crc_reg   <= CRC_INIT;
            hold_data <= '0;
            hold_sop  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_rd_sop) begin
                        state     <= S_WAIT_HDR;
                        crc_reg   <= CRC_INIT;
                        hold_data <= '0;
                        hold_sop  <= 1'b0;
                    end else if (i_rd_vld || i_rd_eop) begin
                        proto_err <= 1'b1;
                    end
                end
                S_WAIT_HDR: begin
                    if (i_rd_sop) begin
                        crc_reg <= CRC_INIT;
                    end else if (i_rd_eop) begin
                        proto_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (i_rd_vld) begin
                        if (!i_pkt_hdr_vld) proto_err <= 1'b1;
                        hold_data <= i_rd_data;
                        hold_sop  <= 1'b1;
                        crc_reg   <= crc_step(crc_reg, i_rd_data);
                        state     <= S_BODY;
                    end
                end
                S_BODY: begin
                    if (i_rd_sop) begin
                        proto_err <= 1'b1;
                        crc_reg   <= CRC_INIT;
                        hold_data <= '0;
                        hold_sop  <= 1'b0;
                        state     <= S_WAIT_HDR;
                    end else if (i_rd_eop) begin
                        state <= S_IDLE;
                    end else if (i_rd_vld) begin
                        hold_data <= i_rd_data;
                        hold_sop  <= 1'b0;
                        crc_reg   <= crc_step(crc_reg, i_rd_data);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output handshake: a word transfers on any cycle with o_tx_vld & i_tx_rdy; while
    // o_tx_vld is high and i_tx_rdy is low every o_tx_* output holds its value.
    assign out_free   = !out_vld || i_tx_rdy;
    assign tx_acc     = out_vld && i_tx_rdy;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_rd    = !fifo_empty && out_free;
    assign bypass     = push && fifo_empty && out_free;
    assign fifo_wr    = push && !bypass && (!fifo_full || fifo_rd);
    assign drop       = push && !bypass && !fifo_wr;
    assign free_cnt   = DEPTH_C - count;

    always_ff @(posedge i_clk) begin
        if (fifo_wr) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_word <= '0;
            out_vld  <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            if (fifo_wr && !fifo_rd)      count <= count + 1'b1;
            else if (!fifo_wr && fifo_rd) count <= count - 1'b1;
            if (drop) ovf_err <= 1'b1;
            // Empty FIFO lets a new word skip straight into the output register.
            if (bypass) begin
                out_word <= push_word;
                out_vld  <= 1'b1;
            end else if (fifo_rd) begin
                out_word <= mem[rd_ptr];
                out_vld  <= 1'b1;
            end else if (tx_acc) begin
                out_vld  <= 1'b0;
            end
        end
    end

    assign o_tx_vld    = out_vld;
    assign o_tx_data   = out_word[DWIDTH-1:0];
    assign o_tx_sop    = out_vld && out_word[DWIDTH];
    assign o_tx_eop    = out_vld && out_word[DWIDTH+1];
    assign o_tx_err    = out_vld && out_word[DWIDTH+2];
    assign o_buf_afull = (free_cnt < AFULL_C);
    assign o_ovf_err   = ovf_err;
    assign o_proto_err = proto_err;
    assign o_dbg_state = state;

`ifdef RD_PKT_OUT_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] crc_err_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt     <= '0;
            crc_err_cnt <= '0;
        end else if (tx_acc && out_word[DWIDTH+1]) begin
            pkt_cnt <= pkt_cnt + 1'b1;
            if (out_word[DWIDTH+2]) crc_err_cnt <= crc_err_cnt + 1'b1;
        end
    end

    assign o_pkt_cnt     = pkt_cnt;
    assign o_crc_err_cnt = crc_err_cnt;
`else
    assign o_pkt_cnt     = 16'h0;
    assign o_crc_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_rd_pkt_out.sv
// Bench for rd_pkt_out: directed packets, a word-level expected queue and a per-cycle output compare.
module tb_rd_pkt_out;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_sop, rd_vld, hdr_vld, rd_eop;
    logic [31:0] rd_data, crc_in;
    logic        buf_afull, tx_vld, tx_rdy, tx_sop, tx_eop, tx_err;
    logic [31:0] tx_data;
    logic        ovf_err, proto_err;
    logic [15:0] pkt_cnt, crc_err_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    rd_pkt_out dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_sop(rd_sop), .i_rd_vld(rd_vld), .i_rd_data(rd_data),
        .i_pkt_hdr_vld(hdr_vld), .i_rd_eop(rd_eop), .i_crc(crc_in),
        .o_buf_afull(buf_afull), .o_tx_vld(tx_vld), .i_tx_rdy(tx_rdy),
        .o_tx_data(tx_data), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop), .o_tx_err(tx_err),
        .o_ovf_err(ovf_err), .o_proto_err(proto_err),
        .o_pkt_cnt(pkt_cnt), .o_crc_err_cnt(crc_err_cnt), .o_dbg_state(dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected entries are {err, eop, sop, data}.
    logic [34:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        m_pend = 1'b0;
    logic [34:0] m_pend_word = '0;
    int          m_drop = 0;
    logic        m_ovf = 1'b0;
    int          m_pkt = 0;
    int          m_err = 0;
    int          n_acc = 0;
    int          hdr_cyc = 0;
    int          sop_cyc = -1;
    logic [31:0] last_err_data = '0;
    logic        stall_q = 1'b0;
    logic [35:0] prev_out = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // CRC step as polynomial division: ((crc ^ word) * x^32) mod P.
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d);
        logic [63:0] r;
        r = {c ^ d, 32'h0};
        for (int i = 63; i >= 32; i--)
            if (r[i]) r = r ^ ({31'h0, 33'h104C11DB7} << (i - 32));
        return r[31:0];
    endfunction

    task automatic drive(input logic sop, input logic vld, input logic hdr, input logic eop,
                         input logic [31:0] d, input logic [31:0] c);
        @(posedge clk);
        #1;
        rd_sop = sop; rd_vld = vld; hdr_vld = hdr; rd_eop = eop; rd_data = d; crc_in = c;
    endtask

    // A word written while the buffer (FIFO plus output register) is full and nothing leaves is lost.
    task automatic model_push(input logic [34:0] e);
        if (exp_q.size() >= DEPTH + 1 && !(tx_vld && tx_rdy)) begin
            m_drop++;
            m_ovf = 1'b1;
        end else begin
            exp_q.push_back(e);
        end
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int n, input logic [31:0] base,
                            input logic bad, input logic trunc);
        logic [31:0] crc;
        logic [31:0] d;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if (m_pend) begin
            model_push({2'b11, m_pend_word[32:0]});
            m_pend = 1'b0;
        end
        crc = 32'hFFFF_FFFF;
        drive(1'b0, 1'b1, 1'b1, 1'b0, hdr, 32'h0);
        hdr_cyc = cyc;
        crc = crc_model(crc, hdr);
        m_pend_word = {3'b001, hdr};
        m_pend = 1'b1;
        for (int k = 0; k < n; k++) begin
            d = base + 32'(k);
            drive(1'b0, 1'b1, 1'b0, 1'b0, d, 32'h0);
            model_push(m_pend_word);
            m_pend_word = {3'b000, d};
            crc = crc_model(crc, d);
        end
        if (!trunc) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, bad ? (crc ^ 32'h1) : crc);
            model_push({bad, 1'b1, m_pend_word[32:0]});
            m_pend = 1'b0;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_drain(input int limit);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || tx_vld) && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("drain_within_budget", 64'(k < limit), 64'd1);
    endtask

    task automatic chk_stats(input string name);
`ifdef RD_PKT_OUT_STATS_EN
        chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkt));
        chk({name, "_crc_err_cnt"}, 64'(crc_err_cnt), 64'(m_err));
`else
        chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        chk({name, "_crc_err_cnt"}, 64'(crc_err_cnt), 64'd0);
`endif
    endtask

    // Output compare: every accepted word against the model, plus stability while stalled.
    always @(negedge clk) begin
        logic [34:0] e;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stall_hold", 64'({tx_vld, tx_err, tx_eop, tx_sop, tx_data}), 64'(prev_out));
            if (tx_vld && tx_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'({tx_err, tx_eop, tx_sop, tx_data}), 64'h7_FFFF_FFFF_F);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_word", 64'({tx_err, tx_eop, tx_sop, tx_data}), 64'(e));
                    n_acc++;
                    if (e[33]) m_pkt++;
                    if (e[33] && e[34]) begin
                        m_err++;
                        last_err_data = e[31:0];
                    end
                    if (e[32] && sop_cyc < 0) sop_cyc = cyc;
                end
            end
            stall_q  = tx_vld && !tx_rdy;
            prev_out = {tx_vld, tx_err, tx_eop, tx_sop, tx_data};
        end
    end

    initial begin
        int acc0;
        rst_n = 1'b0;
        rd_sop = 0; rd_vld = 0; hdr_vld = 0; rd_eop = 0; rd_data = 0; crc_in = 0;
        tx_rdy = 1'b1;

        chk("crc_pin_zero", 64'(crc_model(32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'h0);
        chk("crc_pin_x32", 64'(crc_model(32'hFFFF_FFFF, 32'hFFFF_FFFE)), 64'h04C1_1DB7);
        chk("crc_pin_x33", 64'(crc_model(32'hFFFF_FFFF, 32'hFFFF_FFFD)), 64'h0982_3B6E);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_vld", 64'(tx_vld), 64'd0);
        chk("rst_tx_flags", 64'({tx_data, tx_sop, tx_eop, tx_err}), 64'd0);
        chk("rst_status", 64'({buf_afull, ovf_err, proto_err}), 64'd0);
        chk("rst_counters", 64'({pkt_cnt, crc_err_cnt}), 64'd0);
        chk("rst_state_idle", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Good packet: header plus 16 beats, correct CRC.
        acc0 = n_acc;
        sop_cyc = -1;
        send_pkt(32'hA5A5_0011, 16, 32'h1, 1'b0, 1'b0);
        wait_drain(200);
        chk("pkt1_word_count", 64'(n_acc - acc0), 64'd17);
        chk("pkt1_sop_latency", 64'(sop_cyc - hdr_cyc), 64'd2);

        // Same packet with a corrupted CRC word.
        send_pkt(32'hA5A5_0011, 16, 32'h1, 1'b1, 1'b0);
        wait_drain(200);
        chk("pkt2_model_pkts", 64'(m_pkt), 64'd2);
        chk("pkt2_model_errs", 64'(m_err), 64'd1);
        chk("pkt2_err_last_data", 64'(last_err_data), 64'h10);
        chk_stats("pkt2");

        // Header-only packets.
        acc0 = n_acc;
        send_pkt(32'h0000_0000, 0, 32'h0, 1'b0, 1'b0);
        send_pkt(32'hFFFF_FFFE, 0, 32'h0, 1'b0, 1'b0);
        wait_drain(100);
        chk("hdr_only_words", 64'(n_acc - acc0), 64'd2);
        chk("clean_proto_err", 64'(proto_err), 64'd0);
        chk("clean_ovf_err", 64'(ovf_err), 64'd0);
        chk_stats("hdr_only");

        // New sop after five body beats truncates the open packet.
        send_pkt(32'h1111_0000, 5, 32'h100, 1'b0, 1'b1);
        send_pkt(32'h2222_0000, 4, 32'h200, 1'b0, 1'b0);
        wait_drain(100);
        chk("trunc_proto_err", 64'(proto_err), 64'd1);
        chk("trunc_err_data", 64'(last_err_data), 64'h104);
        chk_stats("trunc");

        // Backpressure: fill until overflow, then drain in order.
        tx_rdy = 1'b0;
        send_pkt(32'h4444_0001, 20, 32'h1000, 1'b0, 1'b0);
        send_pkt(32'h4444_0002, 20, 32'h2000, 1'b0, 1'b0);
        @(negedge clk);
        chk("afull_low_42words", 64'(buf_afull), 64'd0);
        send_pkt(32'h4444_0003, 20, 32'h3000, 1'b0, 1'b0);
        @(negedge clk);
        chk("afull_high_63words", 64'(buf_afull), 64'd1);
        chk("ovf_before_full", 64'(ovf_err), 64'd0);
        send_pkt(32'h4444_0004, 20, 32'h4000, 1'b0, 1'b0);
        @(negedge clk);
        chk("model_dropped", 64'(m_drop), 64'd19);
        chk("ovf_err_set", 64'(ovf_err), 64'(m_ovf));
        @(posedge clk); #1;
        tx_rdy = 1'b1;
        wait_drain(400);
        chk("afull_after_drain", 64'(buf_afull), 64'd0);
        chk_stats("ovf");

        // Reset with ten words buffered and a packet still open.
        tx_rdy = 1'b0;
        send_pkt(32'h3333_0000, 10, 32'h300, 1'b0, 1'b1);
        chk("pre_rst_buffered", 64'(exp_q.size()), 64'd10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 64'({tx_vld, tx_sop, tx_eop, tx_err, tx_data}), 64'd0);
        chk("mid_rst_status", 64'({buf_afull, ovf_err, proto_err, pkt_cnt, crc_err_cnt}), 64'd0);
        exp_q.delete();
        m_pend = 1'b0;
        m_pkt = 0;
        m_err = 0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_rdy = 1'b1;
        acc0 = n_acc;
        send_pkt(32'h5555_0000, 3, 32'h500, 1'b0, 1'b0);
        wait_drain(100);
        chk("post_rst_words", 64'(n_acc - acc0), 64'd4);
        chk("post_rst_errs", 64'({ovf_err, proto_err}), 64'd0);
        chk_stats("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
